// File: rtl/mux_scan_nx1.sv
// Registered N_CH x WIDTH multiplexer with valid/ready output, manual select or
// round-robin scan with a per-channel dwell. Optional macro SCAN_MASK_EN adds a scan channel mask.
module mux_scan_nx1 #(
  parameter int N_CH  = 8,
  parameter int WIDTH = 4,
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [N_CH*WIDTH-1:0]   I,
  input  logic [SEL_W-1:0]        S,
  input  logic                    MODE,
  input  logic                    EN,
  input  logic                    Q_READY,
`ifdef SCAN_MASK_EN
  input  logic [N_CH-1:0]         MASK,
`endif
  output logic [WIDTH-1:0]        Q,
  output logic                    Q_VALID,
  output logic [SEL_W-1:0]        CH,
  output logic                    ERR
);

  localparam int                 CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W:0]     N_CH_L   = (SEL_W + 1)'(N_CH);
  localparam logic [SEL_W-1:0]   CH_LAST  = SEL_W'(N_CH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_MAN, ST_SCAN} state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_q;
  logic               r_q_valid;
  logic [SEL_W-1:0]   r_ch;
  logic               r_err;
  logic [SEL_W-1:0]   r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;

  logic               w_slot_free;
  logic               w_s_bad;
  logic [SEL_W-1:0]   w_s_safe;
  logic [SEL_W-1:0]   w_scan_ch;
  logic               w_scan_any;
  logic [SEL_W-1:0]   w_ptr_inc;
  logic               w_cap;
  logic [SEL_W-1:0]   w_cap_ch;
  logic [WIDTH-1:0]   w_cap_word;
  logic               w_err;

  assign w_slot_free = !r_q_valid || Q_READY;
  assign w_s_bad     = {1'b0, S} >= N_CH_L;
  assign w_s_safe    = w_s_bad ? '0 : S;
  assign w_ptr_inc   = (w_scan_ch == CH_LAST) ? '0 : w_scan_ch + SEL_W'(1);

`ifdef SCAN_MASK_EN
  // Rotate the mask so bit 0 is the pointer, then take the nearest enabled offset.
  logic [N_CH-1:0]  w_rot;
  logic [SEL_W-1:0] w_off;
  logic [SEL_W:0]   w_sum;

  assign w_rot = N_CH'({MASK, MASK} >> r_ptr);

  always_comb begin
    w_off      = '0;
    w_scan_any = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off      = SEL_W'(k);
        w_scan_any = 1'b1;
      end
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= N_CH_L) w_sum = w_sum - N_CH_L;
    w_scan_ch = w_sum[SEL_W-1:0];
  end
`else
  assign w_scan_ch  = r_ptr;
  assign w_scan_any = 1'b1;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_cap       = 1'b0;
    w_cap_ch    = S;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (EN) begin
          w_state_nxt = MODE ? ST_SCAN : ST_MAN;
          w_cnt_nxt   = '0;
        end
      end
      ST_MAN: begin
        if (!EN) begin
          w_state_nxt = ST_IDLE;
        end else begin
          if (w_slot_free) begin
            if (w_s_bad) w_err = 1'b1;
            else         w_cap = 1'b1;
          end
          if (MODE) begin
            w_state_nxt = ST_SCAN;
            w_ptr_nxt   = w_s_safe;
            w_cnt_nxt   = '0;
          end
        end
      end
      ST_SCAN: begin
        if (!EN) begin
          w_state_nxt = ST_IDLE;
        end else begin
          // At the end of the dwell the counter waits for a free slot, so no channel is skipped.
          if (r_cnt == CNT_LAST) begin
            if (w_slot_free && w_scan_any) begin
              w_cap     = 1'b1;
              w_cap_ch  = w_scan_ch;
              w_ptr_nxt = w_ptr_inc;
              w_cnt_nxt = '0;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
          if (!MODE) begin
            w_state_nxt = ST_MAN;
            w_cnt_nxt   = '0;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cap_word = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (w_cap_ch == SEL_W'(k)) w_cap_word = I[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_ch      <= '0;
      r_err     <= 1'b0;
      r_ptr     <= '0;
      r_cnt     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err;
      if (w_cap) begin
        r_q       <= w_cap_word;
        r_ch      <= w_cap_ch;
        r_q_valid <= 1'b1;
      end else if (Q_READY) begin
        r_q_valid <= 1'b0;
      end
    end
  end

  assign Q       = r_q;
  assign Q_VALID = r_q_valid;
  assign CH      = r_ch;
  assign ERR     = r_err;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Scoreboard bench for mux_scan_nx1 (N_CH=6, DWELL=3); mask phase runs when SCAN_MASK_EN is defined.
module tb_mux_scan_nx1;

  localparam int N  = 6;
  localparam int W  = 4;
  localparam int SW = 3;
  localparam int DW = 3;
  localparam int ALL_ON = (1 << N) - 1;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N*W-1:0]  I;
  logic [SW-1:0]   S;
  logic            MODE, EN, Q_READY;
  logic [W-1:0]    Q;
  logic            Q_VALID;
  logic [SW-1:0]   CH;
  logic            ERR;
`ifdef SCAN_MASK_EN
  logic [N-1:0]    MASK;
`endif

  mux_scan_nx1 #(.N_CH(N), .WIDTH(W), .SEL_W(SW), .DWELL(DW)) dut (
    .CLK(CLK), .RST(RST), .I(I), .S(S), .MODE(MODE), .EN(EN), .Q_READY(Q_READY),
`ifdef SCAN_MASK_EN
    .MASK(MASK),
`endif
    .Q(Q), .Q_VALID(Q_VALID), .CH(CH), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int ch;
    int word;
  } exp_t;

  exp_t sb[$];
  int   words[N];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pops   = 0;
  int   scan_ptr = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_words();
    for (int k = 0; k < N; k++) I[k*W +: W] = W'(words[k]);
  endtask

  task automatic count_words();
    for (int k = 0; k < N; k++) words[k] = k + 1;
    drive_words();
  endtask

  task automatic rand_words();
    for (int k = 0; k < N; k++) words[k] = int'($urandom_range(0, 15));
    drive_words();
  endtask

  task automatic push(input int ch);
    exp_t e;
    e.ch   = ch;
    e.word = words[ch];
    sb.push_back(e);
  endtask

  // Reference scan order: next enabled channel at or after 'from', wrapping.
  function automatic int next_en(input int from, input int m);
    for (int j = 0; j < N; j++) begin
      int c;
      c = (from + j) % N;
      if (((m >> c) & 1) != 0) return c;
    end
    return -1;
  endfunction

  task automatic push_scan(input int n, input int m);
    for (int i = 0; i < n; i++) begin
      int c;
      c = next_en(scan_ptr, m);
      push(c);
      scan_ptr = (c + 1) % N;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_pops(input int target, input string name);
    int budget;
    budget = 200;
    while (n_pops < target && budget > 0) begin
      tick();
      budget--;
    end
    check(name, n_pops, target);
  endtask

  // Monitor: a transfer happens on the next edge whenever valid and ready are both high.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST && Q_VALID && Q_READY) begin
      if (sb.size() == 0) begin
        check("unexpected_sample_ch", int'(CH), -1);
      end else begin
        e = sb.pop_front();
        check("mon_ch", int'(CH), e.ch);
        check("mon_q", int'(Q), e.word);
      end
      n_pops++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    RST = 1'b1; EN = 1'b0; MODE = 1'b0; S = '0; Q_READY = 1'b1; I = '0;
`ifdef SCAN_MASK_EN
    MASK = N'(ALL_ON);
`endif
    for (int k = 0; k < N; k++) words[k] = 0;
    #3;
    check("rst_q", int'(Q), 0);
    check("rst_valid", int'(Q_VALID), 0);
    check("rst_ch", int'(CH), 0);
    check("rst_err", int'(ERR), 0);
    tick();
    RST = 1'b0;
    tick();

    // Manual: S=5 with channel k = k+1, then random selects and data every cycle.
    count_words();
    S = 3'd5; MODE = 1'b0; EN = 1'b1;
    tick();
    push(5);
    tick();
    check("man_first_q", int'(Q), 6);
    check("man_first_ch", int'(CH), 5);
    check("man_first_valid", int'(Q_VALID), 1);
    for (int i = 0; i < 8; i++) begin
      S = SW'($urandom_range(0, N - 1));
      rand_words();
      push(int'(S));
      tick();
    end
    EN = 1'b0;
    tick();
    check("man_drain_pops", n_pops, 9);
    check("man_drain_valid", int'(Q_VALID), 0);

    // Out-of-range manual select.
    count_words();
    S = 3'd2; EN = 1'b1;
    tick();
    push(2);
    tick();
    S = 3'd7;
    tick();
    check("err_pulse", int'(ERR), 1);
    check("err_valid", int'(Q_VALID), 0);
    check("err_q_kept", int'(Q), 3);
    check("err_ch_kept", int'(CH), 2);
    S = 3'd1;
    push(1);
    tick();
    check("err_clear", int'(ERR), 0);
    check("err_recover_q", int'(Q), 2);
    EN = 1'b0;
    tick();
    check("err_pops", n_pops, 11);

    // Scan from IDLE: first capture DWELL cycles after entry, then back-pressure.
    base = n_pops;
    count_words();
    scan_ptr = 0;
    MODE = 1'b1; EN = 1'b1; Q_READY = 1'b1;
    push_scan(7, ALL_ON);
    tick();
    check("scan_lat_e1", int'(Q_VALID), 0);
    tick();
    check("scan_lat_e2", int'(Q_VALID), 0);
    tick();
    check("scan_lat_e3", int'(Q_VALID), 0);
    tick();
    check("scan_lat_e4", int'(Q_VALID), 1);
    check("scan_first_ch", int'(CH), 0);
    wait_pops(base + 7, "scan_run_pops");
    push_scan(5, ALL_ON);
    Q_READY = 1'b0;
    for (int b = 0; b < 10 && !Q_VALID; b++) tick();
    for (int c = 0; c < 10; c++) begin
      check("hold_valid", int'(Q_VALID), 1);
      check("hold_ch", int'(CH), sb[0].ch);
      check("hold_q", int'(Q), sb[0].word);
      tick();
    end
    Q_READY = 1'b1;
    wait_pops(base + 12, "scan_resume_pops");
    EN = 1'b0;
    tick();
    tick();
    check("scan_stop_valid", int'(Q_VALID), 0);
    check("scan_sb_empty", sb.size(), 0);

    // Reset between edges with a pending sample, then restart at channel 0.
    base = n_pops;
    rand_words();
    scan_ptr = 0;
    push_scan(3, ALL_ON);
    EN = 1'b1;
    tick();
    wait_pops(base + 3, "pre_reset_pops");
    @(posedge CLK);
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    check("midrst_q", int'(Q), 0);
    check("midrst_valid", int'(Q_VALID), 0);
    check("midrst_ch", int'(CH), 0);
    check("midrst_err", int'(ERR), 0);
    sb.delete();
    tick();
    RST = 1'b0;
    base = n_pops;
    scan_ptr = 0;
    push_scan(2, ALL_ON);
    wait_pops(base + 2, "post_reset_pops");
    EN = 1'b0;
    tick();
    tick();

    // Manual to scan: pointer loads S while a sample is held.
    base = n_pops;
    rand_words();
    Q_READY = 1'b0; MODE = 1'b0; S = 3'd4; EN = 1'b1;
    tick();
    push(4);
    tick();
    MODE = 1'b1;
    tick();
    scan_ptr = 4;
    push_scan(4, ALL_ON);
    Q_READY = 1'b1;
    wait_pops(base + 5, "man2scan_pops");
    EN = 1'b0;
    tick();
    tick();
    check("man2scan_valid", int'(Q_VALID), 0);

`ifdef SCAN_MASK_EN
    // Masked scan from a masked start channel, then an all-zero mask.
    base = n_pops;
    rand_words();
    MASK = 6'b10_0100;
    Q_READY = 1'b0; MODE = 1'b0; S = 3'd3; EN = 1'b1;
    tick();
    push(3);
    tick();
    MODE = 1'b1;
    tick();
    scan_ptr = 3;
    push_scan(4, 'h24);
    Q_READY = 1'b1;
    wait_pops(base + 5, "mask_pops");
    MASK = '0;
    for (int c = 0; c < 12; c++) begin
      tick();
      check("mask_zero_valid", int'(Q_VALID), 0);
    end
    check("mask_zero_pops", n_pops, base + 5);
    EN = 1'b0;
    MASK = N'(ALL_ON);
    tick();
`endif

    tick();
    check("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_nx1.md
Name: mux_scan_nx1

Overview:
- Parametrised, registered successor to the team's 8x1 4-bit multiplexer.
- Selects one of N_CH input words of WIDTH bits and presents it on a registered output with a valid/ready handshake.
- Two modes:
  - Manual: the channel comes from S.
  - Scan: an internal round-robin sequencer steps through channels, dwelling DWELL cycles per channel.
- Sits between the data-source banks and any consumer that needs time-multiplexed sampling.

Parameters:
- N_CH, 8, number of input channels (≥2).
- WIDTH, 4, bits per channel.
- SEL_W, 3, select width; must satisfy 2**SEL_W ≥ N_CH.
- DWELL, 4, cycles between samples in scan mode (≥1).

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- I  input  N_CH*WIDTH  flattened channel words; channel k = I[k*WIDTH +: WIDTH].
- S  input  SEL_W  manual channel select.
- MODE  input  1  0 = manual, 1 = scan.
- EN  input  1  run enable.
- Q_READY  input  1  consumer accepts Q this cycle.
- Q  output  WIDTH  registered selected word.
- Q_VALID  output  1  Q holds an unconsumed sample.
- CH  output  SEL_W  channel index the current Q came from.
- ERR  output  1  one-cycle pulse: manual S ≥ N_CH.

Behaviour:
- Reset (async, RST=1): Q=0, Q_VALID=0, CH=0, ERR=0, scan pointer=0, dwell counter=0, state=IDLE. Reset mid-operation discards any pending sample immediately.
- Slot free ⇔ (Q_VALID==0) || (Q_READY==1). Transfer occurs on an edge with Q_VALID && Q_READY. Without a new capture, Q_VALID clears after a transfer. Q and CH stay stable while Q_VALID && !Q_READY.
- FSM states: IDLE, MAN, SCAN.
  - IDLE: no captures. EN=1 → MAN if MODE=0, SCAN if MODE=1.
  - MAN/SCAN: EN=0 → IDLE. A pending sample stays valid until consumed.
  - MAN→SCAN (MODE 0→1): pointer loads S (or 0 if S ≥ N_CH); counter cleared.
  - SCAN→MAN (MODE 1→0): counter cleared.
- MAN: on each edge with slot free:
  - S < N_CH: Q←I[S], CH←S, Q_VALID←1. Latency: 1 cycle from S/I to Q.
  - S ≥ N_CH: no capture, Q_VALID←0 (if the slot was being consumed), ERR←1 for one cycle.
- SCAN: counter increments 0..DWELL-1 each cycle. When counter==DWELL-1 and slot free:
  - Q←I[ptr], CH←ptr, Q_VALID←1.
  - ptr advances, wrapping N_CH-1→0; counter←0.
  - Back-pressure: if the slot is not free at counter==DWELL-1, the counter holds and ptr does not advance. No channel is ever skipped. Capture happens on the first free edge.
  - DWELL=1: one capture per free cycle.
- The first sample after entering SCAN from IDLE appears DWELL cycles after the entering edge.
- EN low in any state blocks new captures the same edge it is sampled low.
- ERR is 0 outside MAN.

Optional Feature:
- Macro SCAN_MASK_EN.
- Defined:
  - Adds port MASK, input, N_CH bits; bit k=1 enables channel k in scan.
  - Pointer advance goes to the next index after ptr (wrapping) with MASK=1.
  - On entering SCAN, if the loaded ptr is masked, the first capture uses the next enabled channel.
  - MASK all-zero: no captures, counter holds at DWELL-1, Q_VALID drains normally.
  - MASK has no effect in MAN.
- Not defined: MASK port absent; all N_CH channels are scanned in order.

Test Plan:
- Manual mode, defaults, I channel k = k+1, S=5, EN=1, Q_READY=1 → one edge after MAN is entered: Q=6, CH=5, Q_VALID=1; Q follows S changes with 1-cycle latency.
- Manual mode with N_CH=6 overridden, S=7 → ERR pulses for one cycle, Q_VALID=0, Q keeps its last value.
- Scan mode, DWELL=3, Q_READY=1 → captures every 3 cycles; CH sequence 0,1,...,7,0; Q = CH+1.
- Scan mode, Q_READY held 0 for 10 cycles → Q/CH frozen at the first capture; when READY rises, the next capture is the following channel with no skip.
- RST asserted mid-scan between edges → outputs zero immediately; after release and EN=1, scan restarts at CH=0.
- SCAN_MASK_EN defined, MASK=8'b1010_0100 → CH sequence 2,5,7,2; MASK=0 → Q_VALID drops after consumption and stays 0.
